// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used to reject an access before it touches memory.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // The reserved size code is treated as misaligned so it never reaches memory.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane logic: extracts and extends a load lane from a memory
// word, and merges a right-aligned store lane into a memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    lane_b      = mem_word[{offset, 3'b000} +: 8];
    lane_h      = offset[1] ? mem_word[31:16] : mem_word[15:0];
    load_data   = mem_word;
    merged_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_data   = {{24{~is_unsigned & lane_b[7]}}, lane_b};
        merged_word = mem_word;
        merged_word[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data   = {{16{~is_unsigned & lane_h[15]}}, lane_h};
        merged_word = mem_word;
        merged_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time between the core and a synchronous
// word-wide data memory; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              REQ,
  input  logic              WE,
  input  logic [1:0]        SIZE,
  input  logic              UNSIGNED,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              MISALIGN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DIN,
  input  logic [DATA_W-1:0] MEM_DOUT,
  output logic              MEM_WR_EN,
  output logic              MEM_RD_EN
);

  state_t              state_q, state_d;
  logic                we_q, uns_q, mis_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q, rdata_q;
  logic [31:0]         load_data, merged_word;
  logic                accept;

  assign accept = (state_q == ST_IDLE) && REQ;

  lsu_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (addr_q[1:0]),
    .mem_word    (MEM_DOUT),
    .wdata       (din_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RSTN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (REQ) begin
        if (is_misaligned(SIZE, ADDR[1:0])) state_d = ST_FIN;
        else if (WE && SIZE == SZ_WORD)     state_d = ST_WR;
        else                                state_d = ST_RD;
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = we_q ? ST_WR : ST_FIN;
      ST_WR:   state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory strobes decode straight from the state, so reset clears them at once.
  always_comb begin
    BUSY      = state_q != ST_IDLE;
    DONE      = state_q == ST_FIN;
    MISALIGN  = (state_q == ST_FIN) && mis_q;
    MEM_RD_EN = state_q == ST_RD;
    MEM_WR_EN = state_q == ST_WR;
    MEM_ADDR  = (state_q == ST_IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    // NOTE: datapath registers are reset too, because RDATA and MEM_DIN must read zero in reset.
    if (!RSTN) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q   <= WE;
        uns_q  <= UNSIGNED;
        mis_q  <= is_misaligned(SIZE, ADDR[1:0]);
        size_q <= SIZE;
        addr_q <= ADDR;
        if (WE) din_q <= WDATA;
      end
      // CAP sees the word read in RD: loads register the lane, stores the merged word.
      if (state_q == ST_CAP) begin
        if (we_q) din_q   <= merged_word;
        else      rdata_q <= load_data;
      end
    end
  end

  assign RDATA   = rdata_q;
  assign MEM_DIN = din_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a synchronous-read word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        REQ = 1'b0;
  logic        WE = 1'b0;
  logic [1:0]  SIZE = 2'b00;
  logic        UNSIGNED = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] WDATA = '0;
  logic [31:0] RDATA, MEM_ADDR, MEM_DIN, MEM_DOUT;
  logic        BUSY, DONE, MISALIGN, MEM_WR_EN, MEM_RD_EN;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .WE(WE), .SIZE(SIZE), .UNSIGNED(UNSIGNED),
    .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA), .BUSY(BUSY), .DONE(DONE),
    .MISALIGN(MISALIGN), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT),
    .MEM_WR_EN(MEM_WR_EN), .MEM_RD_EN(MEM_RD_EN)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:63];
  logic        tb_we = 1'b0;
  logic [5:0]  tb_idx = '0;
  logic [31:0] tb_data = '0;
  int          cyc = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0, rd_cyc = 0, wr_cyc = 0;
  logic [31:0] wr_data_last = '0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (tb_we) mem[tb_idx] <= tb_data;
    if (MEM_WR_EN) begin
      mem[MEM_ADDR[7:2]] <= MEM_DIN;
      wr_cnt       <= wr_cnt + 1;
      wr_cyc       <= cyc;
      wr_data_last <= MEM_DIN;
    end
    if (MEM_RD_EN) begin
      MEM_DOUT <= mem[MEM_ADDR[7:2]];
      rd_cnt   <= rd_cnt + 1;
      rd_cyc   <= cyc;
    end
    if (MEM_RD_EN && MEM_WR_EN) both_cnt <= both_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  int lat, rd0, wr0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    tb_idx = idx; tb_data = data; tb_we = 1'b1;
    step;
    tb_we = 1'b0;
  endtask

  // Issues one request and returns the number of cycles from acceptance to DONE.
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, output int lat_o);
    WE = we; SIZE = size; UNSIGNED = uns; ADDR = addr; WDATA = wdata; REQ = 1'b1;
    step;
    REQ = 1'b0;
    lat_o = 1;
    while (DONE !== 1'b1 && lat_o < 8) begin
      step;
      lat_o++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, BUSY, 0);
    check({tag, " done"}, DONE, 0);
    check({tag, " misalign"}, MISALIGN, 0);
    check({tag, " rdata"}, RDATA, 0);
    check({tag, " mem_addr"}, MEM_ADDR, 0);
    check({tag, " mem_din"}, MEM_DIN, 0);
    check({tag, " rd_en"}, MEM_RD_EN, 0);
    check({tag, " wr_en"}, MEM_WR_EN, 0);
  endtask

  task automatic load_check(input string tag, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] exp);
    int l;
    int r0;
    r0 = rd_cnt;
    do_access(1'b0, size, uns, addr, 32'h0, l);
    check({tag, " latency"}, l, 3);
    check({tag, " rdata"}, RDATA, exp);
    check({tag, " misalign"}, MISALIGN, 0);
    check({tag, " reads"}, rd_cnt - r0, 1);
    step;
    check({tag, " idle"}, BUSY, 0);
  endtask

  task automatic mis_check(input string tag, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] exp_rdata);
    int l;
    int r0;
    int w0;
    r0 = rd_cnt; w0 = wr_cnt;
    do_access(we, size, 1'b0, addr, 32'hFFFF_FFFF, l);
    check({tag, " latency"}, l, 1);
    check({tag, " misalign"}, MISALIGN, 1);
    check({tag, " rdata"}, RDATA, exp_rdata);
    check({tag, " mem enables"}, (rd_cnt - r0) + (wr_cnt - w0), 0);
    step;
    check({tag, " misalign low"}, MISALIGN, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    check_zero("por");

    preload(6'd4,  32'hDEAD_BEEF);
    preload(6'd8,  32'h80FF_7F01);
    preload(6'd12, 32'h1122_3344);
    preload(6'd20, 32'hCAFE_F00D);
    preload(6'd24, 32'h0000_0000);
    RSTN = 1'b1;

    load_check("ld word",   SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF);
    load_check("ld sbyte3", SZ_BYTE, 1'b0, 32'h23, 32'hFFFF_FF80);
    load_check("ld ubyte1", SZ_BYTE, 1'b1, 32'h21, 32'h0000_007F);
    load_check("ld shalf1", SZ_HALF, 1'b0, 32'h22, 32'hFFFF_80FF);
    load_check("ld uhalf0", SZ_HALF, 1'b1, 32'h20, 32'h0000_7F01);
    load_check("ld sbyte0", SZ_BYTE, 1'b0, 32'h20, 32'h0000_0001);

    rd0 = rd_cnt; wr0 = wr_cnt;
    do_access(1'b1, SZ_HALF, 1'b0, 32'h32, 32'h1234_AAAA, lat);
    check("st half latency", lat, 4);
    check("st half misalign", MISALIGN, 0);
    check("st half din", wr_data_last, 32'hAAAA_3344);
    check("st half rd->wr gap", wr_cyc - rd_cyc, 2);
    check("st half reads", rd_cnt - rd0, 1);
    check("st half writes", wr_cnt - wr0, 1);
    check("st half rdata kept", RDATA, 32'h0000_0001);
    step;
    check("st half mem", mem[12], 32'hAAAA_3344);

    do_access(1'b1, SZ_BYTE, 1'b0, 32'h31, 32'hFFFF_FF55, lat);
    check("st byte latency", lat, 4);
    step;
    check("st byte mem", mem[12], 32'hAAAA_5544);

    rd0 = rd_cnt; wr0 = wr_cnt;
    do_access(1'b1, SZ_WORD, 1'b0, 32'h60, 32'h1234_5678, lat);
    check("st word latency", lat, 2);
    check("st word reads", rd_cnt - rd0, 0);
    check("st word writes", wr_cnt - wr0, 1);
    step;
    check("st word mem", mem[24], 32'h1234_5678);
    check("st word rdata kept", RDATA, 32'h0000_0001);

    mis_check("mis word ld", 1'b0, SZ_WORD, 32'h41, 32'h0000_0001);
    mis_check("mis half st", 1'b1, SZ_HALF, 32'h33, 32'h0000_0001);
    mis_check("mis rsvd ld", 1'b0, SZ_RSVD, 32'h40, 32'h0000_0001);

    wr0 = wr_cnt;
    WE = 1'b1; SIZE = SZ_BYTE; UNSIGNED = 1'b0; ADDR = 32'h50; WDATA = 32'h0000_00EE; REQ = 1'b1;
    step;
    REQ = 1'b0;
    check("abort rd phase", MEM_RD_EN, 1);
    step;
    check("abort cap busy", BUSY, 1);
    #2 RSTN = 1'b0;
    #1;
    check_zero("abort");
    step;
    step;
    RSTN = 1'b1;
    load_check("post reset ld", SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("abort no write", wr_cnt - wr0, 0);
    check("abort mem kept", mem[20], 32'hCAFE_F00D);

    rd0 = rd_cnt;
    WE = 1'b0; SIZE = SZ_WORD; UNSIGNED = 1'b0; ADDR = 32'h10; REQ = 1'b1;
    step;
    ADDR = 32'h20;
    lat = 1;
    while (DONE !== 1'b1 && lat < 8) begin step; lat++; end
    check("held first latency", lat, 3);
    check("held first rdata", RDATA, 32'hDEAD_BEEF);
    step;
    check("held idle gap", BUSY, 0);
    check("held single read", rd_cnt - rd0, 1);
    step;
    check("held second accepted", BUSY, 1);
    check("held second rd_en", MEM_RD_EN, 1);
    REQ = 1'b0;
    lat = 1;
    while (DONE !== 1'b1 && lat < 8) begin step; lat++; end
    check("held second latency", lat, 3);
    check("held second rdata", RDATA, 32'h80FF_7F01);
    check("held two reads", rd_cnt - rd0, 2);
    check("rd/wr never together", both_cnt, 0);
    step;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of ADDR/MEM_ADDR.
REQ-002 SHALL have parameter DATA_W, default 32, data word width (only 32 supported).
REQ-003 SHALL have ports (one clock; reset asynchronous, active-low):
 CLK  in  1  rising-edge clock
 RSTN  in  1  asynchronous active-low reset
 REQ  in  1  core access request, sampled only when BUSY=0
 WE  in  1  1=store, 0=load
 SIZE  in  2  00 byte, 01 half, 10 word, 11 reserved
 UNSIGNED  in  1  load zero-extend (1) / sign-extend (0)
 ADDR  in  ADDR_W  byte address from core
 WDATA  in  32  store data, right-aligned
 RDATA  out  32  extended load result
 BUSY  out  1  unit not idle
 DONE  out  1  one-cycle completion pulse
 MISALIGN  out  1  error flag, valid with DONE
 MEM_ADDR  out  ADDR_W  word address to DATA_MEM, {ADDR[ADDR_W-1:2],2'b00}
 MEM_DIN  out  32  write word to DATA_MEM
 MEM_DOUT  in  32  read word from DATA_MEM
 MEM_WR_EN  out  1  DATA_MEM write enable
 MEM_RD_EN  out  1  DATA_MEM read enable

Function
REQ-004 SHALL implement FSM IDLE, RD, CAP, WR, FIN.
REQ-005 SHALL accept REQ only in IDLE; REQ, WE, SIZE, UNSIGNED, ADDR, WDATA latched on the accepting edge; REQ in other states ignored.
REQ-006 SHALL assert BUSY in every state except IDLE.
REQ-007 Misaligned = SIZE=11, or half with ADDR[0]=1, or word with ADDR[1:0]!=00; SHALL go IDLE->FIN, no memory enable, MISALIGN=1 with DONE, RDATA unchanged.
REQ-008 Load: IDLE->RD (MEM_RD_EN=1)->CAP (MEM_DOUT valid, extract lane, extend, register RDATA)->FIN; DONE in 3rd cycle after acceptance edge.
REQ-009 Word store: IDLE->WR (MEM_WR_EN=1, MEM_DIN=WDATA)->FIN; DONE in 2nd cycle after acceptance.
REQ-010 Byte/half store (read-modify-write): IDLE->RD->CAP (merge WDATA lane into MEM_DOUT, register)->WR (write merged word)->FIN; DONE in 4th cycle.
REQ-011 Lane select: byte lane ADDR[1:0], half lane ADDR[1]; little-endian (byte 0 = bits 7:0).
REQ-012 FIN SHALL assert DONE for exactly one cycle and return to IDLE next edge.
REQ-013 MEM_RD_EN and MEM_WR_EN SHALL never be high together; each high for exactly one cycle per access.
REQ-014 MEM_ADDR held constant from RD/WR entry through FIN; 0 in IDLE.
REQ-015 RDATA SHALL hold last load result until next successful load; stores do not alter RDATA.
REQ-016 MISALIGN SHALL be 0 whenever DONE=0.

Reset
REQ-017 RSTN=0 SHALL immediately force IDLE and zero RDATA, BUSY, DONE, MISALIGN, MEM_ADDR, MEM_DIN, MEM_WR_EN, MEM_RD_EN, independent of CLK.
REQ-018 Reset mid-operation SHALL abort the access; no memory write after RSTN release; first REQ accepted on first edge with RSTN=1.

Structure
REQ-019 Shared package lsu_pkg SHALL hold SIZE encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings.
REQ-020 Combinational lane logic (extract/extend, merge) SHALL be sub-module lsu_align; FSM and registers in load_store_unit.

Verification
REQ-021 Word load: mem[0x10]=0xDEADBEEF, REQ load word ADDR=0x10 -> DONE cycle 3, RDATA=0xDEADBEEF, MISALIGN=0.
REQ-022 Signed/unsigned byte: mem[0x20]=0x80FF7F01, byte load ADDR=0x23 signed -> 0xFFFFFF80; unsigned ADDR=0x21 -> 0x0000007F.
REQ-023 Half store RMW: mem[0x30]=0x11223344, store half WDATA=0xAAAA ADDR=0x32 -> MEM_RD_EN then MEM_WR_EN, MEM_DIN=0xAAAA3344, DONE cycle 4.
REQ-024 Misalign: word load ADDR=0x41 -> DONE cycle 1, MISALIGN=1, no MEM_RD_EN/MEM_WR_EN, RDATA unchanged.
REQ-025 Reset mid-RMW: byte store started, RSTN=0 in CAP -> all outputs 0 asynchronously, no MEM_WR_EN, memory word unchanged.
REQ-026 REQ held high through busy access -> only one access performed; second accepted in the cycle after FIN.
